// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates instruction-fetch and data load/store
// requests onto a single external memory handshake (readM/writeM/address/data,
// completed by rising edges of inputReady/ackOutput). Handshake strobes are
// sampled on clk through optional synchronisers, so nothing is clocked by the
// memory. An access that sees no completion edge within TIMEOUT cycles is
// aborted with err. Successful accesses are counted in acc_count.
module mem_access_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int SYNC_STAGES = 0,
  parameter int TIMEOUT     = 15,
  parameter int TO_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [WORD_SIZE-1:0]  if_rdata,
  output logic                  if_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_SIZE-1:0]  d_wdata,
  output logic [WORD_SIZE-1:0]  d_rdata,
  output logic                  d_done,
  output logic                  err,
  output logic                  busy,
  output logic [WORD_SIZE-1:0]  acc_count,
  output logic                  readM,
  output logic                  writeM,
  output logic [ADDR_WIDTH-1:0] address,
  inout  wire  [WORD_SIZE-1:0]  data,
  input  logic                  inputReady,
  input  logic                  ackOutput
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  typedef enum logic {GNT_FETCH, GNT_DATA} grant_t;

  localparam bit                TO_EN    = (TIMEOUT != 0);
  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT);

  state_t               state;
  grant_t               grant;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 data_oe;
  logic [TO_WIDTH-1:0]  to_cnt;
  logic [TO_WIDTH-1:0]  to_cnt_nxt;
  logic                 timeout_hit;

  logic rdy_sync, ack_sync;
  logic rdy_prev, ack_prev;
  logic rdy_edge, ack_edge;

  // Optional synchroniser chains on the memory strobes.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign rdy_sync = inputReady;
    assign ack_sync = ackOutput;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] rdy_ff;
    logic [SYNC_STAGES-1:0] ack_ff;

    // Shift each strobe through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdy_ff <= '0;
        ack_ff <= '0;
      end else begin
        rdy_ff[0] <= inputReady;
        ack_ff[0] <= ackOutput;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          rdy_ff[i] <= rdy_ff[i-1];
          ack_ff[i] <= ack_ff[i-1];
        end
      end
    end

    assign rdy_sync = rdy_ff[SYNC_STAGES-1];
    assign ack_sync = ack_ff[SYNC_STAGES-1];
  end

  // Previous-cycle copies for rising-edge detection; updated every cycle so a
  // strobe already high on entry to RD/WR never counts as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_prev <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      rdy_prev <= rdy_sync;
      ack_prev <= ack_sync;
    end
  end

  assign rdy_edge = rdy_sync & ~rdy_prev;
  assign ack_edge = ack_sync & ~ack_prev;

  // The timeout fires once the access has spent TIMEOUT full cycles in RD/WR.
  assign to_cnt_nxt  = to_cnt + TO_WIDTH'(1);
  assign timeout_hit = TO_EN && (to_cnt_nxt == TO_LIMIT);

  assign busy = (state != IDLE);
  assign data = data_oe ? wdata_q : 'z;

  // Main access FSM with registered handshake and completion outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every register, including the data word and counters, is cleared
      // asynchronously so a reset mid-access releases the bus at once.
      state     <= IDLE;
      grant     <= GNT_FETCH;
      wdata_q   <= '0;
      data_oe   <= 1'b0;
      to_cnt    <= '0;
      readM     <= 1'b0;
      writeM    <= 1'b0;
      address   <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
      acc_count <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the defaults below make the
      // completion flags single-cycle pulses unless a branch sets them again.
      if_done <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;

      case (state)
        IDLE: begin
          if (d_req) begin
            address <= d_addr;
            grant   <= GNT_DATA;
            to_cnt  <= '0;
            if (d_we) begin
              wdata_q <= d_wdata;
              data_oe <= 1'b1;
              writeM  <= 1'b1;
              state   <= WR;
            end else begin
              readM   <= 1'b1;
              state   <= RD;
            end
          end else if (if_req) begin
            address <= if_addr;
            grant   <= GNT_FETCH;
            to_cnt  <= '0;
            readM   <= 1'b1;
            state   <= RD;
          end
        end

        RD: begin
          if (rdy_edge || timeout_hit) begin
            readM <= 1'b0;
            state <= DONE;
            if (grant == GNT_DATA) d_done  <= 1'b1;
            else                   if_done <= 1'b1;
            if (rdy_edge) begin
              if (grant == GNT_DATA) d_rdata  <= data;
              else                   if_rdata <= data;
              acc_count <= acc_count + WORD_SIZE'(1);
            end else begin
              err <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt_nxt;
          end
        end

        WR: begin
          if (ack_edge || timeout_hit) begin
            writeM  <= 1'b0;
            data_oe <= 1'b0;
            state   <= DONE;
            if (grant == GNT_DATA) d_done  <= 1'b1;
            else                   if_done <= 1'b1;
            if (ack_edge) acc_count <= acc_count + WORD_SIZE'(1);
            else          err       <= 1'b1;
          end else begin
            to_cnt <= to_cnt_nxt;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. Main instance: 16-bit, no
// synchronisers, TIMEOUT=15, checked through a completion scoreboard. Second
// instance: 8-bit, two synchroniser stages, timeout disabled, used for the
// latency, no-timeout and counter-wrap cases.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- main instance ----------------
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        err, busy;
  logic [15:0] acc_count;
  logic        readM, writeM;
  logic [15:0] address;
  wire  [15:0] data_bus;
  logic        inputReady = 1'b0;
  logic        ackOutput = 1'b0;
  logic        mem_drive = 1'b0;
  logic [15:0] mem_rdata = '0;

  assign data_bus = mem_drive ? mem_rdata : 16'hzzzz;

  mem_access_ctrl #(.WORD_SIZE(16), .ADDR_WIDTH(16), .SYNC_STAGES(0),
                    .TIMEOUT(15), .TO_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err), .busy(busy),
    .acc_count(acc_count), .readM(readM), .writeM(writeM), .address(address),
    .data(data_bus), .inputReady(inputReady), .ackOutput(ackOutput)
  );

  // ---------------- second instance ----------------
  logic        b_if_req = 1'b0;
  logic [15:0] b_if_addr = '0;
  logic [7:0]  b_if_rdata;
  logic        b_if_done;
  logic        b_d_req = 1'b0;
  logic        b_d_we = 1'b0;
  logic [15:0] b_d_addr = 16'h0020;
  logic [7:0]  b_d_wdata = '0;
  logic [7:0]  b_d_rdata;
  logic        b_d_done;
  logic        b_err, b_busy;
  logic [7:0]  b_acc;
  logic        b_readM, b_writeM;
  logic [15:0] b_address;
  wire  [7:0]  b_data;
  logic        b_ir = 1'b0;
  logic        b_ack = 1'b0;
  logic        b_mem_drive = 1'b0;
  logic [7:0]  b_mem_rdata = '0;

  assign b_data = b_mem_drive ? b_mem_rdata : 8'hzz;

  mem_access_ctrl #(.WORD_SIZE(8), .ADDR_WIDTH(16), .SYNC_STAGES(2),
                    .TIMEOUT(0), .TO_WIDTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_done(b_if_done),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_done(b_d_done), .err(b_err), .busy(b_busy),
    .acc_count(b_acc), .readM(b_readM), .writeM(b_writeM), .address(b_address),
    .data(b_data), .inputReady(b_ir), .ackOutput(b_ack)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        is_data;
    logic [15:0] rdata;
    logic        err;
    logic [15:0] acc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [15:0] exp_acc = '0;
  logic [15:0] last_d = '0;
  logic [15:0] last_if = '0;
  logic [15:0] exp_wdata = '0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  int          b_rd_cycles = 0;

  task automatic expect_done(input logic is_data, input logic [15:0] rdata, input logic err_e);
    if (!err_e) exp_acc = exp_acc + 16'd1;
    sb_q.push_back('{is_data, rdata, err_e, exp_acc});
    if (is_data) last_d = rdata;
    else         last_if = rdata;
  endtask

  // Completion monitor: pops the oldest expectation on every done pulse.
  always @(negedge clk) begin
    if (reset_n && (if_done || d_done)) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check("sb_chan", {30'b0, if_done, d_done}, sb_e.is_data ? 32'd1 : 32'd2);
        check("sb_rdata", sb_e.is_data ? d_rdata : if_rdata, sb_e.rdata);
        check("sb_err", err, sb_e.err);
        check("sb_acc", acc_count, sb_e.acc);
      end
    end
  end

  // Always-on handshake properties and strobe window counters.
  always @(negedge clk) begin
    if (reset_n) begin
      check("rw_excl", readM & writeM, 0);
      if (writeM) check("wr_bus", data_bus, exp_wdata);
    end
    if (readM)   rd_cycles++;
    if (writeM)  wr_cycles++;
    if (b_readM) b_rd_cycles++;
  end

  // ---------------- helpers (called at posedge + #1) ----------------
  task automatic wait_done(input logic is_data, input string tag);
    int n = 0;
    while (!(is_data ? d_done : if_done) && n < 100) begin @(posedge clk); #1; n++; end
    check(tag, is_data ? d_done : if_done, 1);
    @(posedge clk); #1;
    if (is_data) d_req = 1'b0;
    else         if_req = 1'b0;
  endtask

  task automatic mem_read(input int dly, input logic [15:0] addr_e, input logic [15:0] val);
    int n = 0;
    while (!readM && n < 50) begin @(posedge clk); #1; n++; end
    check("rd_start", readM, 1);
    check("rd_addr", address, addr_e);
    repeat (dly - 1) @(posedge clk);
    #1;
    mem_rdata = val; mem_drive = 1'b1; inputReady = 1'b1;
    n = 0;
    while (readM && n < 50) begin @(posedge clk); #1; n++; end
    inputReady = 1'b0; mem_drive = 1'b0;
  endtask

  task automatic mem_write(input int dly, input logic [15:0] addr_e, input logic [15:0] val);
    int n = 0;
    while (!writeM && n < 50) begin @(posedge clk); #1; n++; end
    check("wr_start", writeM, 1);
    check("wr_addr", address, addr_e);
    check("wr_data", data_bus, val);
    repeat (dly - 1) @(posedge clk);
    #1;
    ackOutput = 1'b1;
    n = 0;
    while (writeM && n < 50) begin @(posedge clk); #1; n++; end
    ackOutput = 1'b0;
  endtask

  // Drive a pattern onto the bus; any leftover controller drive corrupts it.
  task automatic bus_released(input string tag);
    mem_rdata = 16'h0F0F; mem_drive = 1'b1;
    #1;
    check(tag, data_bus, 16'h0F0F);
    mem_drive = 1'b0;
  endtask

  task automatic b_read(input int dly, input logic [7:0] val);
    b_d_req = 1'b1;
    fork
      begin : b_mem
        int m = 0;
        while (!b_readM && m < 20) begin @(posedge clk); #1; m++; end
        repeat (dly - 1) @(posedge clk);
        #1;
        b_mem_rdata = val; b_mem_drive = 1'b1; b_ir = 1'b1;
        m = 0;
        while (b_readM && m < 80) begin @(posedge clk); #1; m++; end
        b_ir = 1'b0; b_mem_drive = 1'b0;
      end
      begin : b_reqr
        int m = 0;
        while (!b_d_done && m < 100) begin @(posedge clk); #1; m++; end
        check("b_done", b_d_done, 1);
        check("b_rdata", b_d_rdata, val);
        check("b_err", b_err, 0);
        @(posedge clk); #1;
        b_d_req = 1'b0;
      end
    join
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_readM", readM, 0);
    check("rst_writeM", writeM, 0);
    check("rst_addr", address, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_dones", {if_done, d_done, err}, 0);
    check("rst_busy", busy, 0);
    check("rst_acc", acc_count, 0);
    bus_released("rst_bus");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Fetch, memory answers 3 cycles after readM rises.
    rd_cycles = 0;
    if_addr = 16'h0010; if_req = 1'b1;
    expect_done(1'b0, 16'hA5A5, 1'b0);
    fork
      wait_done(1'b0, "t1_done");
      mem_read(3, 16'h0010, 16'hA5A5);
    join
    check("t1_rd_cycles", rd_cycles, 3);

    // Store, acknowledged 2 cycles after writeM rises.
    wr_cycles = 0; exp_wdata = 16'h1234;
    d_addr = 16'h0040; d_wdata = 16'h1234; d_we = 1'b1; d_req = 1'b1;
    expect_done(1'b1, last_d, 1'b0);
    fork
      wait_done(1'b1, "t2_done");
      mem_write(2, 16'h0040, 16'h1234);
    join
    d_we = 1'b0;
    check("t2_wr_cycles", wr_cycles, 2);
    bus_released("t2_bus_z");

    // Simultaneous requests: data load first, then the pending fetch.
    d_addr = 16'h0080; d_req = 1'b1;
    if_addr = 16'h0100; if_req = 1'b1;
    expect_done(1'b1, 16'hBEEF, 1'b0);
    expect_done(1'b0, 16'hC0DE, 1'b0);
    fork
      wait_done(1'b1, "t3_d_done");
      wait_done(1'b0, "t3_if_done");
      begin
        mem_read(2, 16'h0080, 16'hBEEF);
        mem_read(2, 16'h0100, 16'hC0DE);
      end
    join
    check("t3_acc", acc_count, exp_acc);

    // Load with no response: abort after 15 cycles in RD.
    rd_cycles = 0;
    d_addr = 16'h0200; d_req = 1'b1;
    expect_done(1'b1, last_d, 1'b1);
    @(posedge clk); #1;
    check("t4_busy", busy, 1);
    wait_done(1'b1, "t4_done");
    check("t4_rd_cycles", rd_cycles, 15);
    check("t4_rdata_kept", d_rdata, 16'hBEEF);

    // inputReady already high before RD entry: only a fresh rising edge counts.
    mem_rdata = 16'h1111; mem_drive = 1'b1; inputReady = 1'b1;
    @(posedge clk); #1;
    rd_cycles = 0;
    if_addr = 16'h0300; if_req = 1'b1;
    expect_done(1'b0, 16'h5A5A, 1'b0);
    fork
      wait_done(1'b0, "t5_done");
      begin
        int n = 0;
        while (!readM && n < 50) begin @(posedge clk); #1; n++; end
        repeat (4) @(posedge clk);
        #1 inputReady = 1'b0;
        @(posedge clk);
        #1 mem_rdata = 16'h5A5A; inputReady = 1'b1;
        n = 0;
        while (readM && n < 50) begin @(posedge clk); #1; n++; end
        inputReady = 1'b0; mem_drive = 1'b0;
      end
    join
    check("t5_rd_cycles", rd_cycles, 6);
    check("t5_acc", acc_count, exp_acc);

    // Reset in the middle of a store.
    exp_wdata = 16'h9999;
    d_addr = 16'h0500; d_wdata = 16'h9999; d_we = 1'b1; d_req = 1'b1;
    begin
      int n = 0;
      while (!writeM && n < 50) begin @(posedge clk); #1; n++; end
    end
    check("t6_in_wr", writeM, 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("t6_writeM", writeM, 0);
    check("t6_readM", readM, 0);
    check("t6_addr", address, 0);
    check("t6_rdata", {if_rdata, d_rdata}, 0);
    check("t6_flags", {if_done, d_done, err, busy}, 0);
    check("t6_acc", acc_count, 0);
    bus_released("t6_bus_z");
    d_req = 1'b0; d_we = 1'b0;
    exp_acc = '0; last_d = '0; last_if = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("sb_drained", sb_q.size(), 0);

    // Two-stage synchroniser: same 3-cycle response completes 2 cycles later.
    b_rd_cycles = 0;
    b_read(3, 8'h3C);
    check("b_sync_latency", b_rd_cycles, 5);

    // Timeout disabled: a 40-cycle response still completes normally.
    b_rd_cycles = 0;
    b_read(40, 8'hC3);
    check("b_no_timeout", b_rd_cycles, 42);
    check("b_acc_2", b_acc, 2);

    // Counter wrap on the 8-bit instance.
    for (int i = 0; i < 253; i++) b_read(1, 8'(i));
    check("b_acc_ff", b_acc, 8'hFF);
    b_read(1, 8'h55);
    check("b_acc_wrap", b_acc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Parametrised memory access controller between the multicycle core and the external memory handshake (readM/writeM/address/data/inputReady/ackOutput).
- Serves two request channels: instruction fetch and data load/store.
- All handshake inputs are sampled on clk with optional synchronisers and rising-edge detection, so no logic is clocked from memory strobes.
- Adds fixed-priority arbitration, a timeout/abort mechanism and a completed-access counter.

Parameters:
- WORD_SIZE, 16, data bus width in bits
- ADDR_WIDTH, 16, address width in bits
- SYNC_STAGES, 0, flops on inputReady/ackOutput before edge detection (0, 1 or 2)
- TIMEOUT, 15, cycles in RD/WR before abort; 0 disables timeout
- TO_WIDTH, 4, timeout counter width; TIMEOUT must be <= 2^TO_WIDTH-1

Ports:
- clk  in  1  system clock, all state on posedge
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  WORD_SIZE  fetched word
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, level, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  WORD_SIZE  store data
- d_rdata  out  WORD_SIZE  load data
- d_done  out  1  one-cycle data completion pulse
- err  out  1  high with done when the access timed out
- busy  out  1  high in any state except IDLE
- acc_count  out  WORD_SIZE  successful completed accesses, wraps
- readM  out  1  memory read strobe
- writeM  out  1  memory write strobe
- address  out  ADDR_WIDTH  registered memory address
- data  inout  WORD_SIZE  bidirectional memory data bus
- inputReady  in  1  memory read-data-valid
- ackOutput  in  1  memory write acknowledge

Behaviour:
- Reset (async, immediate, including mid-access): state IDLE; readM=writeM=0; data=Z; address=0; if_rdata=d_rdata=0; if_done=d_done=err=0; acc_count=0; timeout counter, grant, synchronisers and edge registers cleared.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - d_req=1: latch d_addr to address, grant=DATA; d_we=1 latches d_wdata and goes to WR, else goes to RD.
  - else if_req=1: latch if_addr, grant=FETCH, go to RD.
  - Simultaneous requests: data wins; fetch stays pending and is served after the data DONE.
- RD: readM=1.
  - On sampled rising edge of inputReady: capture data into if_rdata or d_rdata (per grant), increment acc_count, go to DONE.
- WR: writeM=1; data driven with latched wdata only in WR.
  - On sampled rising edge of ackOutput: increment acc_count, go to DONE.
- Edge detection: edge = synced & ~synced_prev; prev updates every cycle.
  - A strobe already high when RD/WR is entered is not an edge; the controller waits for the next rising edge.
- Timeout: counter clears on entry to RD/WR and increments each cycle there.
  - When the counter equals TIMEOUT with no edge (TIMEOUT!=0): go to DONE with err=1; rdata unchanged; acc_count unchanged.
  - An edge in the same cycle as the timeout wins (success).
- DONE: readM=writeM=0; data=Z; granted channel's done=1 for exactly one cycle; err=1 only when aborted; requests ignored; next state IDLE.
  - Requester drops req at the edge that leaves DONE.
- Latency (SYNC_STAGES=0): req seen at edge 0; strobe high after edge 0; edge sampled at edge k; done high during cycle k..k+1. Minimum req-to-done is 2 cycles, plus SYNC_STAGES cycles.
- acc_count wraps from 2^WORD_SIZE-1 to 0.
- readM and writeM are never high together; data is never driven while readM=1.

Test Plan:
- Reset, then if_req=1, if_addr=16'h0010; memory raises inputReady 3 cycles later with data=16'hA5A5 -> readM high 3 cycles, if_rdata=16'hA5A5, if_done one cycle, acc_count=1, err=0.
- d_req=1, d_we=1, d_addr=16'h0040, d_wdata=16'h1234; ackOutput after 2 cycles -> writeM high, data bus=16'h1234 only in WR, d_done pulse, data=Z afterwards.
- if_req and d_req (load 16'h0080) asserted on the same edge -> data load completes first (d_done), then fetch is serviced, each with its own readM window; acc_count +2.
- TIMEOUT=15, no inputReady -> readM drops after 15 cycles, d_done=1 and err=1 same cycle, d_rdata unchanged, acc_count unchanged; TIMEOUT=0 variant waits indefinitely.
- reset_n pulsed low mid-WR -> writeM=0 and data=Z immediately, all outputs at reset values; SYNC_STAGES=2 read -> done 2 cycles later than the SYNC_STAGES=0 case.
- inputReady held high from before RD entry -> no completion until it falls and rises again; acc_count preset near 16'hFFFF wraps to 0.
